// File: rtl/instr_register_param_if.sv
// rtl/instr_register_param_if.sv - request/response bundle for instr_register_param
// master drives requests and entry data; slave (the register) returns entries and FIFO status.
interface instr_register_param_if #(
  parameter int OPW      = 32,
  parameter int OPCODE_W = 4,
  parameter int DEPTH    = 32
);
  localparam int AW = $clog2(DEPTH);

  logic                       mode;
  logic                       load_en;
  logic [OPCODE_W-1:0]        opcode;
  logic signed [OPW-1:0]      operand_a;
  logic signed [OPW-1:0]      operand_b;
  logic [AW-1:0]              write_pointer;
  logic [AW-1:0]              read_pointer;
  logic                       rd_en;

  logic                       instr_valid;
  logic [OPCODE_W-1:0]        instr_opcode;
  logic signed [OPW-1:0]      instr_a;
  logic signed [OPW-1:0]      instr_b;
  logic signed [2*OPW-1:0]    instr_result;
  logic                       full;
  logic                       empty;
  logic [AW:0]                count;
  logic                       wr_overflow;
  logic                       rd_underflow;

  modport master (
    output mode, load_en, opcode, operand_a, operand_b, write_pointer, read_pointer, rd_en,
    input  instr_valid, instr_opcode, instr_a, instr_b, instr_result,
           full, empty, count, wr_overflow, rd_underflow
  );

  modport slave (
    input  mode, load_en, opcode, operand_a, operand_b, write_pointer, read_pointer, rd_en,
    output instr_valid, instr_opcode, instr_a, instr_b, instr_result,
           full, empty, count, wr_overflow, rd_underflow
  );
endinterface

// File: rtl/instr_register_param.sv
// rtl/instr_register_param.sv - instruction register, addressed or FIFO mode, 1-cycle read
// Result stage built only when INSTR_REG_RESULT_EN is defined; otherwise instr_result is 0.
module instr_register_param #(
  parameter int OPW      = 32,
  parameter int OPCODE_W = 4,
  parameter int DEPTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  instr_register_param_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [OPCODE_W-1:0]   op;
    logic signed [OPW-1:0] a;
    logic signed [OPW-1:0] b;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        out_q, out_d;
  logic [AW-1:0] wr_head_q, wr_head_d, rd_head_q, rd_head_d;
  logic [AW:0]   count_q, count_d;
  logic          mode_q, mode_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          mem_we, do_push, do_pop;
  logic [AW-1:0] mem_waddr;
  logic          fifo_full, fifo_empty;

  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);

  always_comb begin
    mode_d    = bus.mode;
    wr_head_d = wr_head_q;
    rd_head_d = rd_head_q;
    count_d   = count_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.write_pointer;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    // A mode change restarts the FIFO; stored entries stay put.
    if (bus.mode != mode_q) begin
      wr_head_d = '0;
      rd_head_d = '0;
      count_d   = '0;
    end
    if (!bus.mode) begin
      mem_we  = bus.load_en;
      out_d   = mem_q[bus.read_pointer];
      valid_d = 1'b1;
    end else if (bus.mode == mode_q) begin
      do_pop    = bus.rd_en && !fifo_empty;
      do_push   = bus.load_en && (!fifo_full || do_pop);
      unf_d     = bus.rd_en && fifo_empty;
      ovf_d     = bus.load_en && !do_push;
      mem_we    = do_push;
      mem_waddr = wr_head_q;
      if (do_pop) begin
        out_d     = mem_q[rd_head_q];
        valid_d   = 1'b1;
        rd_head_d = rd_head_q + AW'(1);
      end
      if (do_push) begin
        wr_head_d = wr_head_q + AW'(1);
      end
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= bus.mode;
      wr_head_q <= '0;
      rd_head_q <= '0;
      count_q   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mode_q    <= mode_d;
      wr_head_q <= wr_head_d;
      rd_head_q <= rd_head_d;
      count_q   <= count_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      if (mem_we) begin
        mem_q[mem_waddr] <= {bus.opcode, bus.operand_a, bus.operand_b};
      end
    end
  end

  assign bus.instr_valid  = valid_q;
  assign bus.instr_opcode = out_q.op;
  assign bus.instr_a      = out_q.a;
  assign bus.instr_b      = out_q.b;
  assign bus.full         = fifo_full;
  assign bus.empty        = fifo_empty;
  assign bus.count        = count_q;
  assign bus.wr_overflow  = ovf_q;
  assign bus.rd_underflow = unf_q;

`ifdef INSTR_REG_RESULT_EN
  logic signed [2*OPW-1:0] result_q, result_d;

  function automatic logic signed [2*OPW-1:0] alu(input entry_t e);
    logic signed [2*OPW-1:0] sa, sb, r;
    sa = {{OPW{e.a[OPW-1]}}, e.a};
    sb = {{OPW{e.b[OPW-1]}}, e.b};
    case (e.op)
      OPCODE_W'(1): r = sa;
      OPCODE_W'(2): r = sb;
      OPCODE_W'(3): r = sa + sb;
      OPCODE_W'(4): r = sa - sb;
      OPCODE_W'(5): r = sa * sb;
      OPCODE_W'(6): r = (sb == '0) ? '0 : sa / sb;
      OPCODE_W'(7): r = (sb == '0) ? '0 : sa % sb;
      default:      r = '0;
    endcase
    return r;
  endfunction

  // Computed from the same mux that loads out_q, so result and entry share one register stage.
  always_comb result_d = alu(out_d);

  always_ff @(posedge clk) begin
    if (reset) result_q <= '0;
    else       result_q <= result_d;
  end

  assign bus.instr_result = result_q;
`else
  assign bus.instr_result = '0;
`endif
endmodule

// File: tb/tb_instr_register_param.sv
// tb/tb_instr_register_param.sv - directed self-checking bench for instr_register_param
module tb_instr_register_param;
  localparam int OPW = 32, OPCODE_W = 4, DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  instr_register_param_if #(.OPW(OPW), .OPCODE_W(OPCODE_W), .DEPTH(DEPTH)) bif ();

  instr_register_param #(.OPW(OPW), .OPCODE_W(OPCODE_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  function automatic logic signed [63:0] exp_res(input logic signed [63:0] v);
`ifdef INSTR_REG_RESULT_EN
    return v;
`else
    return (v & 64'sd0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.load_en = 1'b0;
    bif.rd_en   = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input int a, input int b);
    bif.load_en   = 1'b1;
    bif.opcode    = op;
    bif.operand_a = a;
    bif.operand_b = b;
  endtask

  task automatic test_reset();
    bif.mode = 1'b0; bif.load_en = 1'b1; bif.rd_en = 1'b1;
    bif.opcode = 4'd3; bif.operand_a = 32'd11; bif.operand_b = 32'd22;
    bif.write_pointer = 5'd1; bif.read_pointer = 5'd1;
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({bif.instr_valid, bif.empty, bif.full, bif.count, bif.wr_overflow, bif.rd_underflow} !== {1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_flags: got v=%b e=%b f=%b c=%0d o=%b u=%b need v=0 e=1 f=0 c=0 o=0 u=0",
               bif.instr_valid, bif.empty, bif.full, bif.count, bif.wr_overflow, bif.rd_underflow);
    end
    n_cmp++;
    if ({bif.instr_opcode, bif.instr_a, bif.instr_b, bif.instr_result} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got op=%0d a=%0d b=%0d r=%0d need all 0",
               bif.instr_opcode, bif.instr_a, bif.instr_b, bif.instr_result);
    end
    reset = 1'b0; idle(); bif.read_pointer = 5'd1;
    tick();
    n_cmp++;
    if ({bif.instr_valid, bif.instr_opcode, bif.instr_a, bif.instr_b} !== {1'b1, 4'd0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_read: got v=%b op=%0d a=%0d b=%0d need v=1 op=0 a=0 b=0",
               bif.instr_valid, bif.instr_opcode, bif.instr_a, bif.instr_b);
    end
  endtask

  task automatic test_addressed();
    push(4'd3, 5, -3); bif.write_pointer = 5'd7; bif.read_pointer = 5'd0;
    tick();
    idle(); bif.read_pointer = 5'd7;
    tick();
    n_cmp++;
    if ({bif.instr_valid, bif.instr_opcode, bif.instr_a, bif.instr_b} !== {1'b1, 4'd3, 32'sd5, -32'sd3}) begin
      n_err++;
      $display("FAIL addr_read: got v=%b op=%0d a=%0d b=%0d need v=1 op=3 a=5 b=-3",
               bif.instr_valid, bif.instr_opcode, bif.instr_a, bif.instr_b);
    end
    n_cmp++;
    if (bif.instr_result !== exp_res(64'sd2)) begin
      n_err++;
      $display("FAIL addr_result: got %0d need %0d", bif.instr_result, exp_res(64'sd2));
    end
    push(4'd4, 10, 1); bif.write_pointer = 5'd7; bif.read_pointer = 5'd7;
    tick();
    n_cmp++;
    if ({bif.instr_opcode, bif.instr_a} !== {4'd3, 32'sd5}) begin
      n_err++;
      $display("FAIL addr_same_old: got op=%0d a=%0d need op=3 a=5", bif.instr_opcode, bif.instr_a);
    end
    idle();
    tick();
    n_cmp++;
    if ({bif.instr_opcode, bif.instr_a, bif.instr_b, bif.instr_result} !== {4'd4, 32'sd10, 32'sd1, exp_res(64'sd9)}) begin
      n_err++;
      $display("FAIL addr_same_new: got op=%0d a=%0d b=%0d r=%0d need op=4 a=10 b=1 r=%0d",
               bif.instr_opcode, bif.instr_a, bif.instr_b, bif.instr_result, exp_res(64'sd9));
    end
  endtask

  task automatic test_fifo_fill();
    bif.mode = 1'b1; idle();
    tick();
    n_cmp++;
    if ({bif.instr_valid, bif.empty, bif.count} !== {1'b0, 1'b1, 6'd0}) begin
      n_err++;
      $display("FAIL fifo_enter: got v=%b e=%b c=%0d need v=0 e=1 c=0", bif.instr_valid, bif.empty, bif.count);
    end
    for (int i = 0; i < 32; i++) begin
      push(4'(i), 100 + 3 * i, -i);
      tick();
    end
    n_cmp++;
    if ({bif.full, bif.empty, bif.count} !== {1'b1, 1'b0, 6'd32}) begin
      n_err++;
      $display("FAIL fifo_full: got f=%b e=%b c=%0d need f=1 e=0 c=32", bif.full, bif.empty, bif.count);
    end
    push(4'd9, 999, 999);
    tick();
    n_cmp++;
    if ({bif.wr_overflow, bif.count} !== {1'b1, 6'd32}) begin
      n_err++;
      $display("FAIL fifo_overflow: got o=%b c=%0d need o=1 c=32", bif.wr_overflow, bif.count);
    end
    idle();
    tick();
    n_cmp++;
    if (bif.wr_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_ovf_pulse: got %b need 0", bif.wr_overflow);
    end
    bif.rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_cmp++;
      if ({bif.instr_valid, bif.instr_opcode, bif.instr_a, bif.instr_b} !== {1'b1, 4'(i), 32'(100 + 3 * i), 32'(-i)}) begin
        n_err++;
        $display("FAIL fifo_pop%0d: got v=%b op=%0d a=%0d b=%0d need v=1 op=%0d a=%0d b=%0d", i,
                 bif.instr_valid, bif.instr_opcode, bif.instr_a, bif.instr_b, i % 16, 100 + 3 * i, -i);
      end
    end
    n_cmp++;
    if ({bif.empty, bif.count} !== {1'b1, 6'd0}) begin
      n_err++;
      $display("FAIL fifo_drained: got e=%b c=%0d need e=1 c=0", bif.empty, bif.count);
    end
    tick();
    n_cmp++;
    if ({bif.rd_underflow, bif.instr_valid, bif.instr_a} !== {1'b1, 1'b0, 32'sd193}) begin
      n_err++;
      $display("FAIL fifo_underflow: got u=%b v=%b a=%0d need u=1 v=0 a=193", bif.rd_underflow, bif.instr_valid, bif.instr_a);
    end
    idle();
    tick();
    n_cmp++;
    if (bif.rd_underflow !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_unf_pulse: got %b need 0", bif.rd_underflow);
    end
  endtask

  task automatic test_fifo_wrap();
    for (int i = 0; i < 5; i++) begin
      push(4'd1, 600 + i, 0); tick();
    end
    idle(); bif.rd_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      push(4'd2, 700 + i, 7 * i); tick();
    end
    idle();
    n_cmp++;
    if ({bif.full, bif.count} !== {1'b1, 6'd32}) begin
      n_err++;
      $display("FAIL wrap_full: got f=%b c=%0d need f=1 c=32", bif.full, bif.count);
    end
    bif.rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_cmp++;
      if ({bif.instr_valid, bif.instr_a, bif.instr_b} !== {1'b1, 32'(700 + i), 32'(7 * i)}) begin
        n_err++;
        $display("FAIL wrap_pop%0d: got v=%b a=%0d b=%0d need v=1 a=%0d b=%0d", i,
                 bif.instr_valid, bif.instr_a, bif.instr_b, 700 + i, 7 * i);
      end
    end
    idle();
    n_cmp++;
    if (bif.empty !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_empty: got %b need 1", bif.empty);
    end
  endtask

  task automatic test_back_to_back();
    push(4'd3, 77, 1); bif.rd_en = 1'b1;
    tick();
    n_cmp++;
    if ({bif.rd_underflow, bif.instr_valid, bif.count} !== {1'b1, 1'b0, 6'd1}) begin
      n_err++;
      $display("FAIL empty_push_pop: got u=%b v=%b c=%0d need u=1 v=0 c=1", bif.rd_underflow, bif.instr_valid, bif.count);
    end
    bif.rd_en = 1'b0;
    for (int i = 0; i < 31; i++) begin
      push(4'd1, 200 + i, i); tick();
    end
    push(4'd2, 500, 5); bif.rd_en = 1'b1;
    tick();
    n_cmp++;
    if ({bif.count, bif.full, bif.wr_overflow, bif.instr_valid, bif.instr_a, bif.instr_b} !== {6'd32, 1'b1, 1'b0, 1'b1, 32'sd77, 32'sd1}) begin
      n_err++;
      $display("FAIL full_push_pop: got c=%0d f=%b o=%b v=%b a=%0d b=%0d need c=32 f=1 o=0 v=1 a=77 b=1",
               bif.count, bif.full, bif.wr_overflow, bif.instr_valid, bif.instr_a, bif.instr_b);
    end
    n_cmp++;
    if (bif.instr_result !== exp_res(64'sd78)) begin
      n_err++;
      $display("FAIL full_push_pop_res: got %0d need %0d", bif.instr_result, exp_res(64'sd78));
    end
    bif.load_en = 1'b0;
    tick();
    n_cmp++;
    if ({bif.instr_a, bif.count} !== {32'sd200, 6'd31}) begin
      n_err++;
      $display("FAIL after_full_pop: got a=%0d c=%0d need a=200 c=31", bif.instr_a, bif.count);
    end
    idle();
  endtask

  task automatic test_arith();
    logic [3:0]         ops [6] = '{4'd5, 4'd6, 4'd7, 4'd12, 4'd4, 4'd6};
    logic signed [31:0] av  [6] = '{32'sh80000000, 32'sd9, -32'sd7, 32'sd3, 32'sd3, -32'sd7};
    logic signed [31:0] bv  [6] = '{32'sh80000000, 32'sd0, 32'sd2, 32'sd4, 32'sd10, 32'sd2};
    logic signed [63:0] ev  [6] = '{64'sh4000000000000000, 64'sd0, -64'sd1, 64'sd0, -64'sd7, -64'sd3};
    bif.mode = 1'b0; idle();
    tick();
    for (int i = 0; i < 6; i++) begin
      push(ops[i], av[i], bv[i]); bif.write_pointer = 5'(20 + i);
      tick();
      idle(); bif.read_pointer = 5'(20 + i);
      tick();
      n_cmp++;
      if (bif.instr_result !== exp_res(ev[i])) begin
        n_err++;
        $display("FAIL arith%0d: op=%0d got %0d need %0d", i, ops[i], bif.instr_result, exp_res(ev[i]));
      end
    end
  endtask

  task automatic test_mode_switch();
    bif.mode = 1'b1; idle();
    tick();
    for (int i = 0; i < 5; i++) begin
      push(4'd1, 300 + i, i); tick();
    end
    idle();
    n_cmp++;
    if (bif.count !== 6'd5) begin
      n_err++;
      $display("FAIL switch_fill: got c=%0d need 5", bif.count);
    end
    bif.mode = 1'b0; bif.read_pointer = 5'd2;
    tick();
    n_cmp++;
    if ({bif.count, bif.empty, bif.instr_valid, bif.instr_a} !== {6'd0, 1'b1, 1'b1, 32'sd302}) begin
      n_err++;
      $display("FAIL switch_addr: got c=%0d e=%b v=%b a=%0d need c=0 e=1 v=1 a=302",
               bif.count, bif.empty, bif.instr_valid, bif.instr_a);
    end
    bif.read_pointer = 5'd4;
    tick();
    n_cmp++;
    if ({bif.instr_a, bif.instr_b} !== {32'sd304, 32'sd4}) begin
      n_err++;
      $display("FAIL switch_addr4: got a=%0d b=%0d need a=304 b=4", bif.instr_a, bif.instr_b);
    end
  endtask

  task automatic test_reset_mid();
    bif.mode = 1'b1; idle();
    tick();
    for (int i = 0; i < 3; i++) begin
      push(4'd3, 400 + i, 1); tick();
    end
    idle(); bif.rd_en = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({bif.instr_valid, bif.instr_opcode, bif.instr_a, bif.instr_b, bif.instr_result, bif.count, bif.empty} !==
        {1'b0, 4'd0, 32'd0, 32'd0, 64'd0, 6'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b op=%0d a=%0d b=%0d r=%0d c=%0d e=%b need zeros, e=1",
               bif.instr_valid, bif.instr_opcode, bif.instr_a, bif.instr_b, bif.instr_result, bif.count, bif.empty);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({bif.rd_underflow, bif.instr_valid} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_pop: got u=%b v=%b need u=1 v=0", bif.rd_underflow, bif.instr_valid);
    end
    idle();
  endtask

  initial begin
    bif.mode = 1'b0; bif.load_en = 1'b0; bif.rd_en = 1'b0; bif.opcode = '0;
    bif.operand_a = '0; bif.operand_b = '0; bif.write_pointer = '0; bif.read_pointer = '0;
    test_reset();
    test_addressed();
    test_fifo_fill();
    test_fifo_wrap();
    test_back_to_back();
    test_arith();
    test_mode_switch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_register_param.md
# instr_register_param

Parametrised instruction register for the lab ALU datapath. It stores opcode/operand entries and returns them one cycle later, in one of two modes: random-access addressed (write_pointer/read_pointer) or an auto-sequencing FIFO with full/empty flags and over/underflow reporting. An optional pipelined result stage returns the ALU result computed from each stored entry. It sits between the testbench interface and the downstream checker/ALU, and replaces the fixed-size instruction register.

## Interface
- OPW, 32, operand width (signed operands)
- OPCODE_W, 4, opcode width
- DEPTH, 32, number of entries; power of two, ≥2; AW = $clog2(DEPTH)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mode  in  1  0 = addressed, 1 = FIFO
- load_en  in  1  write/push request
- opcode  in  OPCODE_W  opcode to store
- operand_a, operand_b  in  OPW  signed operands to store
- write_pointer, read_pointer  in  AW  entry addresses (addressed mode only; ignored in FIFO mode)
- rd_en  in  1  pop request (FIFO mode only)
- instr_valid  out  1  output entry valid
- instr_opcode  out  OPCODE_W; instr_a, instr_b  out  OPW  entry read out
- instr_result  out  2*OPW  signed result (see Configuration)
- full, empty  out  1  FIFO status
- count  out  AW+1  FIFO occupancy, 0..DEPTH
- wr_overflow, rd_underflow  out  1  single-cycle error pulses

## Operation
- Reset (clk edge with reset=1): all entries cleared to opcode 0 and operands 0; FIFO pointers and count = 0; empty=1; full=0; instr_valid=0; all instr_* = 0; error pulses = 0. Reset overrides every other input.
- Addressed mode: if load_en=1, the entry at write_pointer is written. Every cycle, the entry at read_pointer is registered to the instr_* outputs, and instr_valid=1 for every cycle after the first non-reset edge.
- Addressed mode, read and write of the same address in one cycle: the output shows the old contents. The new data is visible on the next read.
- FIFO mode push: load_en=1 and (not full, or rd_en=1 with a successful pop in the same cycle) writes at the write head and advances it modulo DEPTH.
- FIFO mode pop: rd_en=1 and not empty registers the entry at the read head to the outputs with instr_valid=1, then advances the read head modulo DEPTH. With no successful pop, instr_valid=0 and the instr_* outputs hold their previous values.
- Push while full with no pop: data is dropped, count is unchanged, and wr_overflow pulses for 1 cycle.
- Pop while empty: rd_underflow pulses for 1 cycle and instr_valid=0.
- Push and pop together:
  - when full, both succeed and count stays DEPTH;
  - when empty, the push succeeds and the pop is an underflow; the pushed data is not bypassed.
- Mode change (mode differs from its value on the previous edge): FIFO heads and count clear to 0 on that edge. Stored entries are retained. Addressed reads and writes resume immediately.
- Result opcodes: 0 ZERO→0, 1 PASSA→a, 2 PASSB→b, 3 ADD→a+b, 4 SUB→a−b, 5 MULT→a*b, 6 DIV→a/b, 7 MOD→a%b; any other opcode→0.
- Result arithmetic: signed and sign-extended to 2*OPW. DIV or MOD with b=0 gives 0.

## Timing
- Read latency: exactly 1 clk from a read_pointer sample or a successful pop to the instr_* outputs. instr_result is aligned with the same output register (no extra cycle).
- Write to readable: data written on edge N is readable on the next edge. A read of that address on edge N+1 presents the data after edge N+1.
- full, empty and count are registered and reflect the state after the current edge. full=(count==DEPTH), empty=(count==0).
- Wrap-around: both FIFO heads wrap from DEPTH−1 to 0. The extra count bit distinguishes full from empty.
- Error pulses are registered and asserted in the cycle after the offending edge.

## Configuration
- INSTR_REG_RESULT_EN defined: the result computation and its output register are built, and instr_result carries the result as specified.
- INSTR_REG_RESULT_EN undefined: no arithmetic logic is built and instr_result is tied to 0. All other behaviour is identical.

## Test plan
- Reset check, DEPTH=32: hold reset 2 cycles → instr_valid=0, empty=1, count=0, all outputs 0. Then an addressed read of any pointer → opcode 0, a=0, b=0.
- Addressed write/read: write ADD, a=5, b=−3 at address 7, then read address 7 → instr_a=5, instr_b=−3, and instr_result=2 (macro on) or 0 (macro off). Same-address read during a write returns the old value.
- FIFO fill and wrap:
  - push 32 entries → full=1, count=32;
  - a 33rd push → wr_overflow pulse, data dropped;
  - pop 32 → entries returned in order, then empty=1;
  - repeat with offset heads to cross the wrap point.
- FIFO simultaneous events:
  - full with push and pop → count stays 32 and the popped entry is correct;
  - empty with push and pop → rd_underflow pulse, instr_valid=0, count=1.
- Arithmetic corners (macro on):
  - MULT a=−2^31, b=−2^31 → 2^62;
  - DIV a=9, b=0 → 0;
  - MOD a=−7, b=2 → −1;
  - opcode 12 → 0.
- Mode switch and reset mid-operation:
  - 5 entries in the FIFO, switch to addressed mode → count=0 and the stored entries are readable by address;
  - assert reset during a FIFO pop → outputs 0 and instr_valid=0 on that edge.
